// File: rtl/dev_output_pkg.sv
// dev_output_pkg: register map offsets and the byte-lane merge helper
// shared by the output bank and its channels.
package dev_output_pkg;

  // DATA[i] sits at DATA_BASE + i; the control registers follow the NCH
  // data words, so MODE_IDX = NCH + MODE_OFS and so on.
  localparam int DATA_BASE  = 0;
  localparam int MODE_OFS   = 0;
  localparam int PULSE_OFS  = 1;
  localparam int STATUS_OFS = 2;
  localparam int COMMIT_OFS = 3;

  // Widest bus the merge helper handles; callers zero-extend into it and
  // truncate the result back to their own width with a size cast.
  localparam int MERGE_W = 256;

  // Replace only the bytes whose enable bit is set.
  function automatic logic [MERGE_W-1:0] merge(input logic [MERGE_W-1:0]   old_v,
                                               input logic [MERGE_W-1:0]   new_v,
                                               input logic [MERGE_W/8-1:0] be);
    logic [MERGE_W-1:0] r;
    r = old_v;
    for (int b = 0; b < MERGE_W/8; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dev_output_chan.sv
// dev_output_chan: one output channel -- live register, pulse counter and
// busy flag. With DEV_OUTPUT_SHADOW_EN defined, writes land in a shadow
// register that is copied to the live output on commit.
module dev_output_chan
  import dev_output_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PULSE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic                commit,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   data,
  input  logic                mode,
  input  logic [PULSE_W-1:0]  pulse_len,
  output logic [DATA_W-1:0]   live,
  output logic [DATA_W-1:0]   rd_val,
  output logic                busy
);

  logic [DATA_W-1:0]  live_q;
  logic [PULSE_W-1:0] cnt_q;
  logic               busy_q;
  logic               load;
  logic               expire;
  logic [DATA_W-1:0]  merged;

`ifdef DEV_OUTPUT_SHADOW_EN
  logic [DATA_W-1:0] shadow_q;

  assign merged = DATA_W'(merge(MERGE_W'(shadow_q), MERGE_W'(data), (MERGE_W/8)'(be)));
  // Commit starts a pulse only when there is something non-zero to show.
  assign load   = commit && mode && (pulse_len != '0) && (shadow_q != '0);
  assign rd_val = shadow_q;

  // Shadow register collects byte-enabled writes until the next commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   shadow_q <= '0;
    else if (wr) shadow_q <= merged;
  end

  // Live output follows the shadow on commit; expiry clears only the live copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       live_q <= '0;
    else if (commit) live_q <= shadow_q;
    else if (expire) live_q <= '0;
  end
`else
  logic unused_commit;

  assign unused_commit = commit;
  assign merged = DATA_W'(merge(MERGE_W'(live_q), MERGE_W'(data), (MERGE_W/8)'(be)));
  // Any DATA write in pulse mode (even with no byte lanes enabled) retriggers.
  assign load   = wr && mode && (pulse_len != '0);
  assign rd_val = live_q;

  // Live output takes writes directly; a write beats a same-edge expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       live_q <= '0;
    else if (wr)     live_q <= merged;
    else if (expire) live_q <= '0;
  end
`endif

  // The count was loaded with PULSE_LEN, so reaching 1->0 ends the pulse
  // after exactly PULSE_LEN cycles of non-zero output.
  assign expire = busy_q && mode && (cnt_q == PULSE_W'(1)) && !load;

  // Pulse counter: reload on a fresh pulse, stop if the channel leaves
  // pulse mode, otherwise count down to expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      cnt_q  <= pulse_len;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (!mode || expire) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  assign live = live_q;
  assign busy = busy_q;

endmodule

// File: rtl/dev_output_bank.sv
// dev_output_bank: memory-mapped bank of NCH output channels with hold and
// pulse modes. Optional double buffering via DEV_OUTPUT_SHADOW_EN.
module dev_output_bank
  import dev_output_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NCH     = 4,
  parameter int ADDR_W  = 4,
  parameter int PULSE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     add,
  input  logic                  write_en,
  input  logic [DATA_W/8-1:0]   byte_en,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     rd_data,
  output logic [NCH*DATA_W-1:0] dev_out,
  output logic [NCH-1:0]        busy
);

  localparam int MODE_IDX   = DATA_BASE + NCH + MODE_OFS;
  localparam int PULSE_IDX  = DATA_BASE + NCH + PULSE_OFS;
  localparam int STATUS_IDX = DATA_BASE + NCH + STATUS_OFS;
  localparam int COMMIT_IDX = DATA_BASE + NCH + COMMIT_OFS;

  logic [31:0]        add_idx;
  logic [NCH-1:0]     mode_q;
  logic [PULSE_W-1:0] pulse_len_q;
  logic [NCH-1:0]     busy_w;
  logic               commit;
  logic [DATA_W-1:0]  chan_rd [NCH];

  assign add_idx = 32'(add);

`ifdef DEV_OUTPUT_SHADOW_EN
  assign commit = write_en && (add_idx == 32'(COMMIT_IDX));
`else
  assign commit = 1'b0;
`endif

  // Control registers: channel mode bits and the pulse length for new loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= '0;
      pulse_len_q <= '0;
    end else if (write_en) begin
      if (add_idx == 32'(MODE_IDX))
        mode_q <= NCH'(merge(MERGE_W'(mode_q), MERGE_W'(data_in), (MERGE_W/8)'(byte_en)));
      if (add_idx == 32'(PULSE_IDX))
        pulse_len_q <= PULSE_W'(merge(MERGE_W'(pulse_len_q), MERGE_W'(data_in),
                                      (MERGE_W/8)'(byte_en)));
    end
  end

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_chan
      dev_output_chan #(
        .DATA_W  (DATA_W),
        .PULSE_W (PULSE_W)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .wr        (write_en && (add_idx == 32'(DATA_BASE + i))),
        .commit    (commit),
        .be        (byte_en),
        .data      (data_in),
        .mode      (mode_q[i]),
        .pulse_len (pulse_len_q),
        .live      (dev_out[i*DATA_W +: DATA_W]),
        .rd_val    (chan_rd[i]),
        .busy      (busy_w[i])
      );
    end
  endgenerate

  // Combinational read mux; COMMIT and unmapped indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (add_idx == 32'(DATA_BASE + c)) rd_data = chan_rd[c];
    end
    if (add_idx == 32'(MODE_IDX))   rd_data = DATA_W'(mode_q);
    if (add_idx == 32'(PULSE_IDX))  rd_data = DATA_W'(pulse_len_q);
    if (add_idx == 32'(STATUS_IDX)) rd_data = DATA_W'(busy_w);
  end

  assign busy = busy_w;

endmodule

// File: tb/tb_dev_output_bank.sv
// tb_dev_output_bank: directed test of dev_output_bank with a queue-based
// scoreboard. Expectations adapt when DEV_OUTPUT_SHADOW_EN is defined.
module tb_dev_output_bank;

  localparam int DATA_W  = 32;
  localparam int NCH     = 4;
  localparam int ADDR_W  = 4;
  localparam int PULSE_W = 16;

  logic                  clk;
  logic                  reset;
  logic [ADDR_W-1:0]     add;
  logic                  write_en;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W-1:0]     rd_data;
  logic [NCH*DATA_W-1:0] dev_out;
  logic [NCH-1:0]        busy;

  typedef struct {
    string       name;
    int          what;
    int          ch;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  dev_output_bank #(
    .DATA_W  (DATA_W),
    .NCH     (NCH),
    .ADDR_W  (ADDR_W),
    .PULSE_W (PULSE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .add      (add),
    .write_en (write_en),
    .byte_en  (byte_en),
    .data_in  (data_in),
    .rd_data  (rd_data),
    .dev_out  (dev_out),
    .busy     (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue an expected value and wake the monitor; what: 0=rd_data, 1=dev_out ch, 2=busy.
  task automatic checkOutput(input string name, input int what, input int ch,
                             input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.what = what;
    c.ch   = ch;
    c.exp  = exp;
    sb.push_back(c);
    ->sample_ev;
    #1;
  endtask

  task automatic readCheck(input string name, input int idx, input logic [31:0] exp);
    add = ADDR_W'(idx);
    #1;
    checkOutput(name, 0, 0, exp);
  endtask

  // One bus write: set up on the falling edge, captured on the rising edge.
  task automatic applyStimulus(input int a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    add      = ADDR_W'(a);
    data_in  = d;
    byte_en  = be;
    write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    byte_en  = '0;
    data_in  = '0;
  endtask

  // Make a DATA write visible on dev_out (adds a commit in the shadow build).
  task automatic writeData(input int ch, input logic [31:0] d, input logic [3:0] be);
    applyStimulus(ch, d, be);
`ifdef DEV_OUTPUT_SHADOW_EN
    applyStimulus(NCH + 3, 32'h0, 4'h0);
`endif
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop every pending expectation and compare with the live DUT outputs.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (sb.size() != 0) begin
        c = sb.pop_front();
        case (c.what)
          0:       act = rd_data;
          1:       act = dev_out[c.ch*DATA_W +: DATA_W];
          default: act = 32'(busy);
        endcase
        n_checks++;
        if (act !== c.exp) begin
          n_fail++;
          $display("[TB] FAIL %s: got %h, expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus sequence.
  initial begin
    reset    = 1'b1;
    write_en = 1'b0;
    add      = '0;
    byte_en  = '0;
    data_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 2, 0, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) readCheck($sformatf("reset_read_%0d", i), i, 32'h0);
    for (int c = 0; c < NCH; c++) checkOutput($sformatf("reset_dev_out_%0d", c), 1, c, 32'h0);

    // Hold mode with byte-lane merge.
    writeData(2, 32'hDEADBEEF, 4'b1111);
    checkOutput("hold_full_write", 1, 2, 32'hDEADBEEF);
    writeData(2, 32'h0000AA00, 4'b0010);
    checkOutput("hold_byte_merge", 1, 2, 32'hDEADAAEF);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("hold_persist", 1, 2, 32'hDEADAAEF);
    readCheck("hold_readback", 2, 32'hDEADAAEF);

    // Control registers; MODE upper bits read as zero.
    applyStimulus(NCH + 1, 32'd5, 4'b1111);
    applyStimulus(NCH, 32'hFFFFFFFF, 4'b1111);
    readCheck("mode_upper_zero", NCH, 32'hF);
    applyStimulus(NCH, 32'h1, 4'b1111);
    readCheck("mode_readback", NCH, 32'h1);
    readCheck("pulse_len_readback", NCH + 1, 32'd5);

    // Basic pulse of 5 cycles.
    writeData(0, 32'h1, 4'b1111);
    checkOutput("pulse_on", 1, 0, 32'h1);
    checkOutput("pulse_busy_on", 2, 0, 32'h1);
    readCheck("status_during_pulse", NCH + 2, 32'h1);
    for (int k = 1; k < 5; k++) begin
      nextCycle();
      checkOutput($sformatf("pulse_high_c%0d", k), 1, 0, 32'h1);
    end
    nextCycle();
    checkOutput("pulse_off", 1, 0, 32'h0);
    checkOutput("pulse_busy_off", 2, 0, 32'h0);
`ifdef DEV_OUTPUT_SHADOW_EN
    readCheck("pulse_shadow_kept", 0, 32'h1);
`else
    readCheck("pulse_data_cleared", 0, 32'h0);
`endif

    // Retrigger at cycle 3: 5 more cycles with the new value.
    writeData(0, 32'h1, 4'b1111);
    nextCycle();
    nextCycle();
    writeData(0, 32'h3, 4'b1111);
    checkOutput("retrig_value", 1, 0, 32'h3);
    for (int k = 1; k < 5; k++) begin
      nextCycle();
      checkOutput($sformatf("retrig_high_c%0d", k), 1, 0, 32'h3);
    end
    nextCycle();
    checkOutput("retrig_off", 1, 0, 32'h0);

    // Write on the expiry edge wins and reloads the counter.
    writeData(0, 32'h1, 4'b1111);
    repeat (4) nextCycle();
    writeData(0, 32'h7, 4'b1111);
    checkOutput("expiry_write_data", 1, 0, 32'h7);
    checkOutput("expiry_write_busy", 2, 0, 32'h1);
    repeat (4) nextCycle();
    checkOutput("expiry_write_still", 1, 0, 32'h7);
    nextCycle();
    checkOutput("expiry_write_off", 1, 0, 32'h0);

    // PULSE_LEN = 0 behaves as hold.
    applyStimulus(NCH + 1, 32'd0, 4'b1111);
    writeData(0, 32'h9, 4'b1111);
    repeat (10) nextCycle();
    checkOutput("len0_hold", 1, 0, 32'h9);
    checkOutput("len0_no_busy", 2, 0, 32'h0);

    // A byte_en=0 write still retriggers without changing data.
    applyStimulus(NCH + 1, 32'd3, 4'b1111);
    writeData(0, 32'h2, 4'b1111);
    nextCycle();
    writeData(0, 32'hFF, 4'b0000);
    checkOutput("be0_retrig_data", 1, 0, 32'h2);
    checkOutput("be0_retrig_busy", 2, 0, 32'h1);
    nextCycle();
    nextCycle();
    checkOutput("be0_retrig_still", 1, 0, 32'h2);
    nextCycle();
    checkOutput("be0_retrig_off", 1, 0, 32'h0);

    // Clearing MODE while busy stops the pulse and holds the data.
    applyStimulus(NCH + 1, 32'd5, 4'b1111);
    writeData(0, 32'h4, 4'b1111);
    applyStimulus(NCH, 32'h0, 4'b1111);
    repeat (2) nextCycle();
    checkOutput("mode_clear_busy", 2, 0, 32'h0);
    repeat (8) nextCycle();
    checkOutput("mode_clear_hold", 1, 0, 32'h4);

    // Changing PULSE_LEN mid-pulse only affects the next load.
    applyStimulus(NCH, 32'h1, 4'b1111);
    writeData(0, 32'h1, 4'b1111);
    applyStimulus(NCH + 1, 32'd2, 4'b1111);
    repeat (3) nextCycle();
    checkOutput("len_change_running", 1, 0, 32'h1);
    nextCycle();
    checkOutput("len_change_expired", 1, 0, 32'h0);
    writeData(0, 32'h1, 4'b1111);
    nextCycle();
    checkOutput("len_new_high", 1, 0, 32'h1);
    nextCycle();
    checkOutput("len_new_off", 1, 0, 32'h0);

    // Asynchronous reset in the middle of a pulse.
    applyStimulus(NCH + 1, 32'd5, 4'b1111);
    writeData(0, 32'h1, 4'b1111);
    nextCycle();
    nextCycle();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_out", 1, 0, 32'h0);
    checkOutput("async_reset_busy", 2, 0, 32'h0);
    readCheck("async_reset_mode", NCH, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Unmapped index: write ignored, reads zero.
    applyStimulus(15, 32'hFFFFFFFF, 4'b1111);
    readCheck("unmapped_read", 15, 32'h0);
    readCheck("unmapped_mode", NCH, 32'h0);
    readCheck("unmapped_pulse", NCH + 1, 32'h0);
    for (int c = 0; c < NCH; c++) checkOutput($sformatf("unmapped_dev_out_%0d", c), 1, c, 32'h0);

    // Shadow/commit behaviour (or its absence in the default build).
    applyStimulus(1, 32'h55, 4'b1111);
    readCheck("shadow_readback", 1, 32'h55);
`ifdef DEV_OUTPUT_SHADOW_EN
    checkOutput("shadow_not_live", 1, 1, 32'h0);
    applyStimulus(NCH + 3, 32'h0, 4'b0000);
    checkOutput("commit_live", 1, 1, 32'h55);
`else
    checkOutput("direct_live", 1, 1, 32'h55);
    applyStimulus(NCH + 3, 32'hFFFFFFFF, 4'b1111);
    checkOutput("commit_ignored", 1, 1, 32'h55);
`endif
    readCheck("commit_reads_zero", NCH + 3, 32'h0);

    repeat (2) nextCycle();
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
